vga_layer_renderer: RTL and testbench

Pipelined, parametrised pixel renderer for the game display: takes VGA timing coordinates, game state, player/bank geometry and NUM_OBS obstacle rectangles, and produces registered RGB. Object geometry is double-buffered and latched once per frame so mid-frame updates never tear. It adds per-frame player/obstacle collision detection and a frame-counted game-over blink. It sits between the VGA timing generator, game control and the DAC pins.

---
 rtl/vga_layer_renderer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_vga_layer_renderer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_layer_renderer
//  Purpose  : Two-stage pipelined pixel renderer for the game display.
//             Object geometry is shadowed once per frame (on frame_start)
//             so that mid-frame updates never tear.
//             Stage 1 registers per-pixel hit flags.
//             Stage 2 registers the colour mux.
//             A frame-counted blink drives the GAME_OVER background.
//  Options  : VGA_COLLIDE_EN -- when defined, adds per-frame player/obstacle
//             collision detection. When undefined, collision is tied to 0.
//  Ports    : clk, rst (sync, active-low)
//             x, y, active_pixels, frame_start : VGA timing inputs
//             game_state : 00 START, 01 PLAYING, 10 INSTRUCTIONS,
//                          11 GAME_OVER
//             txt_*      : text-layer pixel flags, aligned with x/y
//             player_x, player_height, obs_* , obs_valid : live geometry
//             VGA_R/G/B  : registered colour, 2-cycle latency
//             collision  : overlap seen during the previous frame
//  Revision : 1.0 - initial release
// ============================================================================
module vga_layer_renderer #(
  parameter int NUM_OBS         = 4,
  parameter int COLOR_W         = 8,
  parameter int BOX_WIDTH       = 30,
  parameter int BOX_BASE_HEIGHT = 30,
  parameter int BOX_Y_START     = 345,
  parameter int BANK_X_START    = 50,
  parameter int BANK_WIDTH      = 60,
  parameter int BLINK_FRAMES    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    active_pixels,
  input  logic                    frame_start,
  input  logic [1:0]              game_state,
  input  logic                    txt_start,
  input  logic                    txt_howto,
  input  logic                    txt_score,
  input  logic                    txt_hp,
  input  logic [9:0]              player_x,
  input  logic [9:0]              player_height,
  input  logic [10*NUM_OBS-1:0]   obs_x,
  input  logic [10*NUM_OBS-1:0]   obs_y,
  input  logic [10*NUM_OBS-1:0]   obs_w,
  input  logic [10*NUM_OBS-1:0]   obs_h,
  input  logic [NUM_OBS-1:0]      obs_valid,
  output logic [COLOR_W-1:0]      VGA_R,
  output logic [COLOR_W-1:0]      VGA_G,
  output logic [COLOR_W-1:0]      VGA_B,
  output logic                    collision
);

  localparam logic [1:0] ST_START   = 2'b00;
  localparam logic [1:0] ST_PLAYING = 2'b01;
  localparam logic [1:0] ST_INSTR   = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  localparam int                  BLINK_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [COLOR_W-1:0]  C_MAX      = '1;
  localparam logic [COLOR_W-1:0]  C_HALF     = {1'b1, {(COLOR_W-1){1'b0}}};

  // All geometry is compared in 11 bits so x+w beyond 1023 never wraps.
  localparam logic [10:0] PL_WIDTH   = 11'(BOX_WIDTH);
  localparam logic [10:0] ROW_BOTTOM = 11'(BOX_Y_START);
  localparam logic [10:0] ROW_LIMIT  = 11'(BOX_Y_START + 1);
  localparam logic [10:0] BANK_X0    = 11'(BANK_X_START);
  localparam logic [10:0] BANK_X1    = 11'(BANK_X_START + BANK_WIDTH);
  localparam logic [10:0] BANK_TOP   = (BOX_BASE_HEIGHT > BOX_Y_START + 1) ? 11'd0
                                       : 11'(BOX_Y_START + 1 - BOX_BASE_HEIGHT);

  // ---------------------------------------------------------------- shadows
  logic [9:0]            sh_player_x;
  logic [9:0]            sh_player_h;
  logic [10*NUM_OBS-1:0] sh_obs_x;
  logic [10*NUM_OBS-1:0] sh_obs_y;
  logic [10*NUM_OBS-1:0] sh_obs_w;
  logic [10*NUM_OBS-1:0] sh_obs_h;
  logic [NUM_OBS-1:0]    sh_obs_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_player_x  <= '0;
      sh_player_h  <= '0;
      sh_obs_x     <= '0;
      sh_obs_y     <= '0;
      sh_obs_w     <= '0;
      sh_obs_h     <= '0;
      sh_obs_valid <= '0;
    end else if (frame_start) begin
      sh_player_x  <= player_x;
      sh_player_h  <= player_height;
      sh_obs_x     <= obs_x;
      sh_obs_y     <= obs_y;
      sh_obs_w     <= obs_w;
      sh_obs_h     <= obs_h;
      sh_obs_valid <= obs_valid;
    end
  end

  // -------------------------------------------------------- stage 1 (hits)
  logic [10:0]        x_ext;
  logic [10:0]        y_ext;
  logic [10:0]        player_top;
  logic               hit_player;
  logic               hit_bank;
  logic [NUM_OBS-1:0] hit_obs;

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};

  // A player taller than the play area is clamped to start at row 0.
  assign player_top = ({1'b0, sh_player_h} > ROW_LIMIT) ? 11'd0
                      : ROW_LIMIT - {1'b0, sh_player_h};

  assign hit_player = (sh_player_h != 10'd0)
                   && (x_ext >= {1'b0, sh_player_x})
                   && (x_ext <  {1'b0, sh_player_x} + PL_WIDTH)
                   && (y_ext >= player_top) && (y_ext <= ROW_BOTTOM);

  assign hit_bank = (x_ext >= BANK_X0) && (x_ext < BANK_X1)
                 && (y_ext >= BANK_TOP) && (y_ext <= ROW_BOTTOM);

  // Zero width or height makes the half-open range empty on its own.
  for (genvar i = 0; i < NUM_OBS; i++) begin : g_obs
    logic [10:0] ox, oy, ow, oh;
    assign ox = {1'b0, sh_obs_x[10*i +: 10]};
    assign oy = {1'b0, sh_obs_y[10*i +: 10]};
    assign ow = {1'b0, sh_obs_w[10*i +: 10]};
    assign oh = {1'b0, sh_obs_h[10*i +: 10]};
    assign hit_obs[i] = sh_obs_valid[i]
                     && (x_ext >= ox) && (x_ext < ox + ow)
                     && (y_ext >= oy) && (y_ext < oy + oh);
  end

  logic               s1_player, s1_bank, s1_active;
  logic [NUM_OBS-1:0] s1_obs;
  logic               s1_txt_start, s1_txt_howto, s1_txt_score, s1_txt_hp;
  logic [1:0]         s1_state;
  logic [9:0]         s1_x, s1_y;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_player    <= 1'b0;
      s1_bank      <= 1'b0;
      s1_obs       <= '0;
      s1_active    <= 1'b0;
      s1_txt_start <= 1'b0;
      s1_txt_howto <= 1'b0;
      s1_txt_score <= 1'b0;
      s1_txt_hp    <= 1'b0;
      s1_state     <= ST_START;
      s1_x         <= '0;
      s1_y         <= '0;
    end else begin
      s1_player    <= hit_player;
      s1_bank      <= hit_bank;
      s1_obs       <= hit_obs;
      s1_active    <= active_pixels;
      s1_txt_start <= txt_start;
      s1_txt_howto <= txt_howto;
      s1_txt_score <= txt_score;
      s1_txt_hp    <= txt_hp;
      s1_state     <= game_state;
      s1_x         <= x;
      s1_y         <= y;
    end
  end

  // ------------------------------------------------------------------ blink
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (game_state != ST_OVER) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // ------------------------------------------------------ stage 2 (colour)
  logic [COLOR_W-1:0] nxt_r, nxt_g, nxt_b;
  logic [10:0]        s1_x_ext, s1_y_ext;
  logic [9:0]         y_mod40;
  logic               on_diag;

  assign s1_x_ext = {1'b0, s1_x};
  assign s1_y_ext = {1'b0, s1_y};
  assign y_mod40  = s1_y % 10'd40;
  assign on_diag  = (s1_x_ext == s1_y_ext + 11'd80) || (s1_x_ext == 11'd720 - s1_y_ext);

  always_comb begin
    nxt_r = '0;
    nxt_g = '0;
    nxt_b = '0;
    if (s1_active) begin
      case (s1_state)
        ST_START: begin
          if (s1_txt_start || s1_txt_howto) begin
            nxt_r = C_MAX; nxt_g = C_MAX; nxt_b = C_MAX;
          end else begin
            nxt_b = C_HALF;
          end
        end
        ST_INSTR: begin
          if ((s1_x > 10'd200) && (s1_x < 10'd440) && (y_mod40 > 10'd35)) begin
            nxt_r = C_MAX; nxt_g = C_MAX; nxt_b = C_MAX;
          end else begin
            nxt_g = C_MAX;
          end
        end
        ST_PLAYING: begin
          if (s1_txt_score || s1_txt_hp) begin
            // black text over everything
          end else if (|s1_obs) begin
            nxt_r = C_MAX;
          end else if (s1_player) begin
            nxt_b = C_MAX;
          end else if (s1_bank) begin
            nxt_g = C_MAX;
          end else begin
            nxt_r = C_MAX; nxt_g = C_MAX; nxt_b = C_MAX;
          end
        end
        default: begin
          if (!on_diag && !blink_phase) nxt_r = C_MAX;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else begin
      VGA_R <= nxt_r;
      VGA_G <= nxt_g;
      VGA_B <= nxt_b;
    end
  end

  // -------------------------------------------------------------- collision
`ifdef VGA_COLLIDE_EN
  logic coll_sticky;
  logic coll_set;

  assign coll_set = s1_active && (s1_state == ST_PLAYING) && s1_player && (|s1_obs);

  // The pixel sitting in stage 1 at the frame_start edge still belongs to
  // the finishing frame, so it is folded into the reported result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      coll_sticky <= 1'b0;
      collision   <= 1'b0;
    end else if (frame_start) begin
      collision   <= coll_sticky | coll_set;
      coll_sticky <= 1'b0;
    end else begin
      coll_sticky <= coll_sticky | coll_set;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_layer_renderer
//  Purpose  : Self-checking bench for vga_layer_renderer. A cycle-level
//             reference model computes colours from the drawing rules.
//             A vector table covers the colour rules; directed sequences
//             cover shadowing, reset, blink, overflow and collision; a
//             random phase exercises the rest.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_layer_renderer;

  localparam int NOBS = 4;
  localparam int BF   = 2;
`ifdef VGA_COLLIDE_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [9:0]           x, y;
  logic                 active_pixels, frame_start;
  logic [1:0]           game_state;
  logic                 txt_start, txt_howto, txt_score, txt_hp;
  logic [9:0]           player_x, player_height;
  logic [10*NOBS-1:0]   obs_x, obs_y, obs_w, obs_h;
  logic [NOBS-1:0]      obs_valid;
  logic [7:0]           VGA_R, VGA_G, VGA_B;
  logic                 collision;

  vga_layer_renderer #(.NUM_OBS(NOBS), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
    .frame_start(frame_start), .game_state(game_state),
    .txt_start(txt_start), .txt_howto(txt_howto), .txt_score(txt_score), .txt_hp(txt_hp),
    .player_x(player_x), .player_height(player_height),
    .obs_x(obs_x), .obs_y(obs_y), .obs_w(obs_w), .obs_h(obs_h), .obs_valid(obs_valid),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .collision(collision)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------- reference model
  int          m_px, m_ph;
  int          m_ox[NOBS], m_oy[NOBS], m_ow[NOBS], m_oh[NOBS];
  bit          m_ov[NOBS];
  bit          m_phase;
  int          m_cnt;
  logic [23:0] m_s1col, m_out;
  bit          m_s1set, m_sticky, m_coll;

  function automatic logic [23:0] ref_pixel(input int px, input int py, input bit act,
                                            input int st, input bit ts, input bit th,
                                            input bit tsc, input bit thp, input bit ph,
                                            output bit setc);
    bit on_obs, on_pl, on_bank;
    int ptop;
    logic [23:0] res;
    on_obs = 0;
    for (int i = 0; i < NOBS; i++)
      if (m_ov[i] && px >= m_ox[i] && px < m_ox[i] + m_ow[i] &&
          py >= m_oy[i] && py < m_oy[i] + m_oh[i]) on_obs = 1;
    ptop    = (m_ph > 346) ? 0 : 346 - m_ph;
    on_pl   = (m_ph > 0) && px >= m_px && px < m_px + 30 && py >= ptop && py <= 345;
    on_bank = px >= 50 && px < 110 && py >= 316 && py <= 345;
    setc    = act && st == 1 && on_pl && on_obs;
    res     = 24'h000000;
    if (act) begin
      case (st)
        0: res = (ts || th) ? 24'hFFFFFF : 24'h000080;
        2: res = (px > 200 && px < 440 && (py % 40) > 35) ? 24'hFFFFFF : 24'h00FF00;
        1: begin
          if (tsc || thp)   res = 24'h000000;
          else if (on_obs)  res = 24'hFF0000;
          else if (on_pl)   res = 24'h0000FF;
          else if (on_bank) res = 24'h00FF00;
          else              res = 24'hFFFFFF;
        end
        default: res = (px == py + 80 || px == 720 - py || ph) ? 24'h000000 : 24'hFF0000;
      endcase
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance one clock, updating the model with this cycle's inputs, then
  // compare the DUT outputs against the model.
  task automatic tick();
    bit sc;
    if (!rst) begin
      m_out = 0; m_s1col = 0; m_s1set = 0; m_sticky = 0; m_coll = 0;
      m_phase = 0; m_cnt = 0; m_px = 0; m_ph = 0;
      for (int i = 0; i < NOBS; i++) begin
        m_ox[i] = 0; m_oy[i] = 0; m_ow[i] = 0; m_oh[i] = 0; m_ov[i] = 0;
      end
    end else begin
      m_out = m_s1col;
      if (frame_start) begin
        m_coll = m_sticky | m_s1set;
        m_sticky = 0;
      end else begin
        m_sticky = m_sticky | m_s1set;
      end
      if (game_state != 2'd3) begin
        m_cnt = 0; m_phase = 0;
      end else if (frame_start) begin
        if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = ~m_phase; end
        else m_cnt++;
      end
      m_s1col = ref_pixel(int'(x), int'(y), active_pixels, int'(game_state), txt_start,
                          txt_howto, txt_score, txt_hp, m_phase, sc);
      m_s1set = sc;
      if (frame_start) begin
        m_px = int'(player_x); m_ph = int'(player_height);
        for (int i = 0; i < NOBS; i++) begin
          m_ox[i] = int'(obs_x[10*i +: 10]); m_oy[i] = int'(obs_y[10*i +: 10]);
          m_ow[i] = int'(obs_w[10*i +: 10]); m_oh[i] = int'(obs_h[10*i +: 10]);
          m_ov[i] = obs_valid[i];
        end
      end
    end
    @(posedge clk);
    #1;
    check("model_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, m_out});
    check("model_collision", {31'h0, collision}, {31'h0, COLL_EN ? m_coll : 1'b0});
  endtask

  task automatic set_pixel(input int px, input int py, input bit act, input logic [1:0] st,
                           input logic [3:0] txt);
    x = 10'(px); y = 10'(py); active_pixels = act; game_state = st;
    {txt_start, txt_howto, txt_score, txt_hp} = txt;
  endtask

  // Hold one pixel for the full pipeline latency and compare with a constant.
  task automatic show(input int px, input int py, input logic [1:0] st,
                      input string name, input logic [23:0] exp);
    set_pixel(px, py, 1'b1, st, 4'b0000);
    frame_start = 1'b0;
    tick();
    tick();
    check(name, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp});
  endtask

  task automatic latch_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic clear_obs();
    obs_x = '0; obs_y = '0; obs_w = '0; obs_h = '0; obs_valid = '0;
  endtask

  typedef struct {
    int          px, py;
    bit          act;
    logic [1:0]  st;
    logic [3:0]  txt;   // {start, howto, score, hp}
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[21];
  logic [23:0] blink_exp[5];

  initial begin
    tbl[0]  = '{70, 330, 1, 2'd1, 4'b0010, 24'h000000};
    tbl[1]  = '{65, 330, 1, 2'd1, 4'b0000, 24'hFF0000};
    tbl[2]  = '{85, 330, 1, 2'd1, 4'b0000, 24'h0000FF};
    tbl[3]  = '{100, 340, 1, 2'd1, 4'b0000, 24'h00FF00};
    tbl[4]  = '{10, 10, 1, 2'd1, 4'b0000, 24'hFFFFFF};
    tbl[5]  = '{65, 330, 0, 2'd1, 4'b0000, 24'h000000};
    tbl[6]  = '{65, 330, 1, 2'd1, 4'b0001, 24'h000000};
    tbl[7]  = '{10, 10, 1, 2'd0, 4'b0000, 24'h000080};
    tbl[8]  = '{10, 10, 1, 2'd0, 4'b1000, 24'hFFFFFF};
    tbl[9]  = '{10, 10, 1, 2'd0, 4'b0100, 24'hFFFFFF};
    tbl[10] = '{300, 36, 1, 2'd2, 4'b0000, 24'hFFFFFF};
    tbl[11] = '{300, 35, 1, 2'd2, 4'b0000, 24'h00FF00};
    tbl[12] = '{200, 39, 1, 2'd2, 4'b0000, 24'h00FF00};
    tbl[13] = '{439, 79, 1, 2'd2, 4'b0000, 24'hFFFFFF};
    tbl[14] = '{100, 20, 1, 2'd3, 4'b0000, 24'h000000};
    tbl[15] = '{300, 20, 1, 2'd3, 4'b0000, 24'hFF0000};
    tbl[16] = '{700, 20, 1, 2'd3, 4'b0000, 24'h000000};
    tbl[17] = '{60, 316, 1, 2'd1, 4'b0000, 24'h0000FF};
    tbl[18] = '{90, 330, 1, 2'd1, 4'b0000, 24'h00FF00};
    tbl[19] = '{79, 359, 1, 2'd1, 4'b0000, 24'hFF0000};
    tbl[20] = '{80, 330, 1, 2'd1, 4'b0000, 24'h0000FF};
    blink_exp = '{24'hFF0000, 24'hFF0000, 24'h000000, 24'h000000, 24'hFF0000};

    rst = 1'b0; frame_start = 1'b0; player_x = '0; player_height = '0;
    clear_obs();
    set_pixel(10, 10, 1'b1, 2'd1, 4'b0000);
    repeat (3) tick();
    check("reset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("reset_collision", {31'h0, collision}, 32'h0);
    rst = 1'b1;

    // ---- colour rules / priority table
    obs_x[9:0] = 10'd40; obs_y[9:0] = 10'd320; obs_w[9:0] = 10'd40; obs_h[9:0] = 10'd40;
    obs_valid = 4'b0001; player_x = 10'd60; player_height = 10'd30;
    latch_frame();
    for (int i = 0; i < 21; i++) begin
      set_pixel(tbl[i].px, tbl[i].py, tbl[i].act, tbl[i].st, tbl[i].txt);
      tick();
      tick();
      check($sformatf("table[%0d]", i), {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, tbl[i].exp});
    end

    // ---- shadowing: live change is invisible until frame_start
    clear_obs(); player_height = '0;
    obs_x[9:0] = 10'd100; obs_y[9:0] = 10'd100; obs_w[9:0] = 10'd20; obs_h[9:0] = 10'd20;
    obs_valid = 4'b0001;
    latch_frame();
    show(105, 105, 2'd1, "shadow_old_a", 24'hFF0000);
    obs_x[9:0] = 10'd300;
    show(105, 105, 2'd1, "shadow_old_b", 24'hFF0000);
    show(305, 105, 2'd1, "shadow_new_hidden", 24'hFFFFFF);
    latch_frame();
    show(305, 105, 2'd1, "shadow_new_live", 24'hFF0000);
    show(105, 105, 2'd1, "shadow_old_gone", 24'hFFFFFF);

    // ---- overflow: x+w past 1023 does not wrap
    obs_x[9:0] = 10'd1000; obs_w[9:0] = 10'd100; obs_y[9:0] = 10'd10; obs_h[9:0] = 10'd20;
    latch_frame();
    show(1010, 15, 2'd1, "overflow_in", 24'hFF0000);
    show(5, 15, 2'd1, "overflow_nowrap", 24'hFFFFFF);
    show(1023, 29, 2'd1, "overflow_edge", 24'hFF0000);

    // ---- collision: one overlapping frame, then a clean one
    clear_obs();
    obs_x[19:10] = 10'd60; obs_y[19:10] = 10'd330; obs_w[19:10] = 10'd20; obs_h[19:10] = 10'd10;
    obs_valid = 4'b0010; player_x = 10'd60; player_height = 10'd30;
    latch_frame();
    set_pixel(65, 335, 1'b1, 2'd1, 4'b0000);
    tick(); tick();
    set_pixel(10, 10, 1'b1, 2'd1, 4'b0000);
    latch_frame();
    check("collision_set", {31'h0, collision}, {31'h0, COLL_EN});
    repeat (5) tick();
    check("collision_hold", {31'h0, collision}, {31'h0, COLL_EN});
    latch_frame();
    check("collision_clear", {31'h0, collision}, 32'h0);

    // ---- reset mid-frame while drawing PLAYING pixels
    set_pixel(10, 10, 1'b1, 2'd1, 4'b0000);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("midreset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("midreset_collision", {31'h0, collision}, 32'h0);
    rst = 1'b1;
    tick();
    check("release_cycle1", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    tick();
    check("release_cycle2", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FFFFFF);

    // ---- blink with BLINK_FRAMES=2
    show(300, 20, 2'd1, "pre_blink", 24'hFFFFFF);
    show(300, 20, 2'd3, "blink_0", blink_exp[0]);
    for (int k = 1; k < 5; k++) begin
      latch_frame();
      tick(); tick();
      check($sformatf("blink_%0d", k), {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, blink_exp[k]});
    end
    show(100, 20, 2'd3, "blink_diag", 24'h000000);

    // ---- random traffic against the model
    game_state = 2'd1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) game_state = 2'($urandom_range(0, 3));
      x = 10'($urandom_range(0, 511)); y = 10'($urandom_range(0, 511));
      active_pixels = ($urandom_range(0, 9) != 0);
      txt_start = ($urandom_range(0, 9) == 0); txt_howto = ($urandom_range(0, 9) == 0);
      txt_score = ($urandom_range(0, 9) == 0); txt_hp    = ($urandom_range(0, 9) == 0);
      frame_start = ($urandom_range(0, 39) == 0);
      player_x = 10'($urandom_range(0, 511)); player_height = 10'($urandom_range(0, 400));
      for (int i = 0; i < NOBS; i++) begin
        obs_x[10*i +: 10] = 10'($urandom_range(0, 1023));
        obs_y[10*i +: 10] = 10'($urandom_range(0, 511));
        obs_w[10*i +: 10] = 10'($urandom_range(0, 300));
        obs_h[10*i +: 10] = 10'($urandom_range(0, 300));
      end
      obs_valid = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst = 1'b1; frame_start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
